// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one pipelined adder among NUM_REQ requesters, responses tagged by ID.
// Define ADDER_ARB_STATS_EN to add per-requester saturating grant counters (stat_sel/stat_clr/stat_count).
module adder_share_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int ADDER_LATENCY = 2,
    parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          add_enable,
    output logic [DATA_WIDTH-1:0]         add_a,
    output logic [DATA_WIDTH-1:0]         add_b,
    input  logic [DATA_WIDTH-1:0]         add_sum,
    output logic                          resp_valid,
    output logic [ID_WIDTH-1:0]           resp_id,
    output logic [DATA_WIDTH-1:0]         resp_sum
`ifdef ADDER_ARB_STATS_EN
    ,
    input  logic [ID_WIDTH-1:0]           stat_sel,
    input  logic                          stat_clr,
    output logic [15:0]                   stat_count
`endif
);
    logic [ID_WIDTH-1:0] rr_q, rr_d, gnt;
    logic [ID_WIDTH:0] idx_sum;
    logic [NUM_REQ-1:0] rot;
    logic hs;
    logic en_q, en_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [ADDER_LATENCY-1:0] tv_q, tv_d;
    logic [ADDER_LATENCY-1:0][ID_WIDTH-1:0] tid_q, tid_d;
    logic rv_q, rv_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;

    // Rotate valids so bit 0 is the requester at rr_q; the lowest set bit wins
    always_comb begin
        rot = NUM_REQ'({req_valid, req_valid} >> rr_q);
        hs = 1'b0;
        idx_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[k]) begin
                hs = 1'b1;
                idx_sum = {1'b0, rr_q} + (ID_WIDTH+1)'(k);
            end
        gnt = idx_sum >= (ID_WIDTH+1)'(NUM_REQ) ? ID_WIDTH'(idx_sum - (ID_WIDTH+1)'(NUM_REQ)) : ID_WIDTH'(idx_sum);
        req_ready = hs ? NUM_REQ'(1) << gnt : '0;
        rr_d = hs ? (gnt == ID_WIDTH'(NUM_REQ - 1) ? '0 : gnt + 1'b1) : rr_q;
        en_d = hs;
        id_d = hs ? gnt : id_q;
        a_d = a_q;
        b_d = b_q;
        for (int k = 0; k < NUM_REQ; k++)
            if (hs && gnt == ID_WIDTH'(k)) begin
                a_d = req_a[k*DATA_WIDTH +: DATA_WIDTH];
                b_d = req_b[k*DATA_WIDTH +: DATA_WIDTH];
            end
        tv_d[0] = en_q;
        tid_d[0] = id_q;
        for (int k = 1; k < ADDER_LATENCY; k++) begin
            tv_d[k] = tv_q[k-1];
            tid_d[k] = tid_q[k-1];
        end
        rv_d = tv_q[ADDER_LATENCY-1];
        rid_d = tid_q[ADDER_LATENCY-1];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rr_q  <= '0;
            en_q  <= 1'b0;
            id_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            tv_q  <= '0;
            tid_q <= '0;
            rv_q  <= 1'b0;
            rid_q <= '0;
        end else begin
            rr_q  <= rr_d;
            en_q  <= en_d;
            id_q  <= id_d;
            a_q   <= a_d;
            b_q   <= b_d;
            tv_q  <= tv_d;
            tid_q <= tid_d;
            rv_q  <= rv_d;
            rid_q <= rid_d;
        end

    assign add_enable = en_q;
    assign add_a      = a_q;
    assign add_b      = b_q;
    assign resp_valid = rv_q;
    assign resp_id    = rid_q;
    assign resp_sum   = add_sum;

`ifdef ADDER_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] cnt_q, cnt_d;

    always_comb begin
        stat_count = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cnt_d[k] = stat_clr ? 16'h0 :
                       (hs && gnt == ID_WIDTH'(k) && cnt_q[k] != 16'hFFFF) ? cnt_q[k] + 16'h1 : cnt_q[k];
            if (stat_sel == ID_WIDTH'(k))
                stat_count = cnt_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
`endif
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed and random traffic against a queue-based reference of grant order and response timing.
module tb_adder_share_arbiter;
    localparam int N = 4, W = 16, LAT = 2, IW = 2;

    logic clk = 1'b0, rst_n = 1'b1;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*W-1:0] req_a = '0, req_b = '0;
    logic add_enable, resp_valid;
    logic [W-1:0] add_a, add_b, add_sum, resp_sum;
    logic [IW-1:0] resp_id;
    logic [W-1:0] apipe [LAT+1];
    int total = 0, bad = 0, edges = 0, rr = 0;
    logic exp_en = 1'b0;
    logic [W-1:0] last_a = '0, last_b = '0;
    typedef struct {int due; int id; logic [W-1:0] sum;} op_t;
    op_t q[$];

`ifdef ADDER_ARB_STATS_EN
    logic [IW-1:0] stat_sel = '0;
    logic stat_clr = 1'b0;
    logic [15:0] stat_count;
`endif

    adder_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .ADDER_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .add_enable(add_enable), .add_a(add_a), .add_b(add_b),
        .add_sum(add_sum), .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum)
`ifdef ADDER_ARB_STATS_EN
        , .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_count(stat_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    // Stand-in adder: (A+B)/2, result visible LAT cycles after the sampling edge
    function automatic logic [W-1:0] fx(logic [W-1:0] a, logic [W-1:0] b);
        logic signed [W:0] s;
        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
        return s[W:1];
    endfunction

    always @(posedge clk) begin
        apipe[0] <= fx(add_a, add_b);
        for (int i = 1; i <= LAT; i++) apipe[i] <= apipe[i-1];
    end
    assign add_sum = apipe[LAT];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(logic [N-1:0] v, logic [N*W-1:0] a, logic [N*W-1:0] b);
        int g;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        chk("add_enable", add_enable, exp_en);
        chk("add_a", add_a, last_a);
        chk("add_b", add_b, last_b);
        if (q.size() > 0 && q[0].due == edges) begin
            chk("resp_valid", resp_valid, 1);
            chk("resp_id", resp_id, q[0].id);
            chk("resp_sum", resp_sum, q[0].sum);
            void'(q.pop_front());
        end else
            chk("resp_valid", resp_valid, 0);
        req_valid = v;
        req_a = a;
        req_b = b;
        #1;
        g = -1;
        for (int k = 0; k < N && g < 0; k++)
            if (v[(rr + k) % N]) g = (rr + k) % N;
        exp_rdy = g < 0 ? '0 : N'(1) << g;
        chk("req_ready", req_ready, exp_rdy);
        exp_en = g >= 0;
        if (g >= 0) begin
            last_a = a[g*W +: W];
            last_b = b[g*W +: W];
            q.push_back('{edges + 2 + LAT, g, fx(last_a, last_b)});
            rr = (g + 1) % N;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_enable", add_enable, 0);
        chk("rst_resp", resp_valid, 0);
        chk("rst_add_a", add_a, 0);
        q.delete();
        rr = 0;
        exp_en = 1'b0;
        last_a = '0;
        last_b = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle(int n);
        repeat (n) step('0, req_a, req_b);
    endtask

    initial begin
        do_reset();
        idle(1);
        step(4'b0001, 64'h0000_0000_0000_0050, 64'h0000_0000_0000_2030);
        idle(LAT + 3);
        step(4'b0100, 64'h0000_7FFF_0000_0000, 64'h0000_7FFF_0000_0000);
        step(4'b0010, 64'h0000_0000_C000_0000, 64'h0000_0000_E018_0000);
        idle(LAT + 3);
        do_reset();
        repeat (8) step(4'b1111, {$urandom, $urandom}, {$urandom, $urandom});
        idle(LAT + 3);
        do_reset();
        step(4'b0010, {$urandom, $urandom}, {$urandom, $urandom});
        step(4'b1010, {$urandom, $urandom}, {$urandom, $urandom});
        step(4'b1010, {$urandom, $urandom}, {$urandom, $urandom});
        idle(LAT + 3);
        step(4'b0011, {$urandom, $urandom}, {$urandom, $urandom});
        step(4'b0011, {$urandom, $urandom}, {$urandom, $urandom});
        do_reset();
        idle(LAT + 4);
        step(4'b1111, {$urandom, $urandom}, {$urandom, $urandom});
        repeat (400) step(N'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        idle(LAT + 3);
        chk("drained", q.size(), 0);
`ifdef ADDER_ARB_STATS_EN
        do_reset();
        repeat (5) step(4'b0100, {$urandom, $urandom}, {$urandom, $urandom});
        idle(1);
        stat_sel = 2'd2;
        #1;
        chk("stat_count5", stat_count, 5);
        stat_clr = 1'b1;
        idle(1);
        stat_clr = 1'b0;
        #1;
        chk("stat_clear", stat_count, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
